// File: rtl/hdmi_stream_ctrl.sv
// hdmi_stream_ctrl
// Frame-level sequencer for the HDMI pass-through datapath. It waits for TX PLL
// lock, aligns pixel capture to the start of an incoming RX frame, holds the TX
// timing generator in restart until the processed-pixel FIFO holds PREFILL
// words, and then watches for FIFO underflow and lost input frames. Either event
// sends the chain through a flush (RESYNC) and back to frame alignment.
//
// Ports:
//   clk            pixel clock; every input is synchronous to it
//   rstbtn_n       asynchronous active-low reset
//   pll_lckd       TX PLL / BUFPLL lock; losing it forces IDLE
//   rx_vsync       decoded RX vsync, already in the clk domain
//   fifo_level     processed-FIFO read-side word count
//   fifo_empty     processed-FIFO empty flag
//   rd_active      timing generator active video (FIFO read enable)
//   capture_en     RX pixel FIFO write gate (high in FILL and RUN)
//   fifo_flush     synchronous clear to both FIFOs (high in RESYNC)
//   timing_restart timing generator restart (low only in RUN)
//   running        status LED (high only in RUN)
//   underflow_cnt  saturating count of underflow events
//   frame_cnt      wrapping count of frames completed in RUN
//   state          current state encoding
module hdmi_stream_ctrl #(
    parameter int                   LEVEL_W      = 11,
    parameter logic [LEVEL_W-1:0]   PREFILL      = 11'd640,
    parameter int                   TIMEOUT_W    = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT      = 20'd840000,
    parameter int                   FLUSH_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rstbtn_n,
    input  logic               pll_lckd,
    input  logic               rx_vsync,
    input  logic [LEVEL_W-1:0] fifo_level,
    input  logic               fifo_empty,
    input  logic               rd_active,
    output logic               capture_en,
    output logic               fifo_flush,
    output logic               timing_restart,
    output logic               running,
    output logic [7:0]         underflow_cnt,
    output logic [15:0]        frame_cnt,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VS = 3'd1,
        ST_FILL    = 3'd2,
        ST_RUN     = 3'd3,
        ST_RESYNC  = 3'd4
    } state_t;

    localparam logic [7:0]           FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST   = TIMEOUT - TIMEOUT_W'(1);

    state_t               state_q, state_d;
    logic                 vs_d_q;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [7:0]           flush_q, flush_d;
    logic [7:0]           ucnt_q, ucnt_d;
    logic [15:0]          fcnt_q, fcnt_d;
    logic                 capture_q, capture_d;
    logic                 flush_o_q, flush_o_d;
    logic                 restart_q, restart_d;
    logic                 running_q, running_d;

    logic                 vs_rise_s;
    logic                 underflow_s;
    logic                 timeout_s;

    // vs_d resets high so a vsync already high at reset release is not an edge.
    assign vs_rise_s   = rx_vsync & ~vs_d_q;
    assign underflow_s = (state_q == ST_RUN) & rd_active & fifo_empty;
    // The timeout fires even if a vsync rise arrives in the same cycle.
    assign timeout_s   = ((state_q == ST_FILL) | (state_q == ST_RUN)) & (tmo_q == TMO_LAST);

    // Next-state, counter and output decode; outputs follow the next state so
    // they register on the same edge as the state itself.
    always_comb begin
        state_d = state_q;
        tmo_d   = {TIMEOUT_W{1'b0}};
        flush_d = flush_q;
        ucnt_d  = ucnt_q;
        fcnt_d  = fcnt_q;

        if (!pll_lckd) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_VS;
                end
                ST_WAIT_VS: begin
                    if (vs_rise_s) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_WAIT_VS;
                    end
                end
                ST_FILL: begin
                    tmo_d = vs_rise_s ? {TIMEOUT_W{1'b0}} : (tmo_q + TIMEOUT_W'(1));
                    if (timeout_s) begin
                        state_d = ST_RESYNC;
                        flush_d = FLUSH_LOAD;
                    end else if (fifo_level >= PREFILL) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_RUN: begin
                    tmo_d = vs_rise_s ? {TIMEOUT_W{1'b0}} : (tmo_q + TIMEOUT_W'(1));
                    if (underflow_s) begin
                        state_d = ST_RESYNC;
                        flush_d = FLUSH_LOAD;
                        ucnt_d  = (ucnt_q == 8'd255) ? ucnt_q : (ucnt_q + 8'd1);
                    end else if (timeout_s) begin
                        state_d = ST_RESYNC;
                        flush_d = FLUSH_LOAD;
                    end else begin
                        state_d = ST_RUN;
                        fcnt_d  = vs_rise_s ? (fcnt_q + 16'd1) : fcnt_q;
                    end
                end
                ST_RESYNC: begin
                    if (flush_q == 8'd0) begin
                        state_d = ST_WAIT_VS;
                    end else begin
                        state_d = ST_RESYNC;
                        flush_d = flush_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        capture_d = (state_d == ST_FILL) | (state_d == ST_RUN);
        flush_o_d = (state_d == ST_RESYNC);
        restart_d = (state_d != ST_RUN);
        running_d = (state_d == ST_RUN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rstbtn_n) begin
        if (!rstbtn_n) begin
            state_q   <= ST_IDLE;
            vs_d_q    <= 1'b1;
            tmo_q     <= {TIMEOUT_W{1'b0}};
            flush_q   <= 8'd0;
            ucnt_q    <= 8'd0;
            fcnt_q    <= 16'd0;
            capture_q <= 1'b0;
            flush_o_q <= 1'b0;
            restart_q <= 1'b1;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_d_q    <= rx_vsync;
            tmo_q     <= tmo_d;
            flush_q   <= flush_d;
            ucnt_q    <= ucnt_d;
            fcnt_q    <= fcnt_d;
            capture_q <= capture_d;
            flush_o_q <= flush_o_d;
            restart_q <= restart_d;
            running_q <= running_d;
        end
    end

    assign capture_en     = capture_q;
    assign fifo_flush     = flush_o_q;
    assign timing_restart = restart_q;
    assign running        = running_q;
    assign underflow_cnt  = ucnt_q;
    assign frame_cnt      = fcnt_q;
    assign state          = state_q;

endmodule

// File: tb/tb_hdmi_stream_ctrl.sv
// Testbench for hdmi_stream_ctrl: a table of directed startup/run vectors
// followed by hand-written sequences for flush length, timeout, simultaneous
// events, lock loss, underflow saturation and asynchronous reset. The frame
// timeout is shortened to keep the run short.
module tb_hdmi_stream_ctrl;

    localparam logic [19:0] TMO = 20'd200;

    logic        clk;
    logic        rstbtn_n;
    logic        pll_lckd;
    logic        rx_vsync;
    logic [10:0] fifo_level;
    logic        fifo_empty;
    logic        rd_active;
    logic        capture_en;
    logic        fifo_flush;
    logic        timing_restart;
    logic        running;
    logic [7:0]  underflow_cnt;
    logic [15:0] frame_cnt;
    logic [2:0]  state;

    int nvec = 0;
    int nerr = 0;
    int exp_fc = 0;
    int exp_uc = 0;

    hdmi_stream_ctrl #(
        .LEVEL_W(11), .PREFILL(11'd640), .TIMEOUT_W(20), .TIMEOUT(TMO), .FLUSH_CYCLES(16)
    ) dut (
        .clk(clk), .rstbtn_n(rstbtn_n), .pll_lckd(pll_lckd), .rx_vsync(rx_vsync),
        .fifo_level(fifo_level), .fifo_empty(fifo_empty), .rd_active(rd_active),
        .capture_en(capture_en), .fifo_flush(fifo_flush), .timing_restart(timing_restart),
        .running(running), .underflow_cnt(underflow_cnt), .frame_cnt(frame_cnt), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        pll;
        logic        vs;
        logic [10:0] lvl;
        logic        emp;
        logic        rd;
        logic [2:0]  st;
        logic        cap;
        logic        fl;
        logic        rs;
        logic        run;
        logic [15:0] fc;
        logic [7:0]  uc;
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s);
        for (int i = 0; i < 100; i++) begin
            if (state == s) break;
            tick();
        end
        chk("wait_state", {29'd0, state}, {29'd0, s});
    endtask

    // From WAIT_VS: vsync edge into FILL, then prefill reached into RUN.
    task automatic to_run();
        wait_state(3'd1);
        pll_lckd = 1'b1; rd_active = 1'b0; fifo_empty = 1'b0; fifo_level = 11'd0;
        rx_vsync = 1'b0; tick();
        rx_vsync = 1'b1; tick();
        fifo_level = 11'd640; tick();
        chk("to_run state", {29'd0, state}, 32'd3);
    endtask

    initial begin
        int fcount;
        //              pll   vs    lvl      emp   rd    st    cap   fl    rs    run   fc      uc
        tbl[0]  = '{1'b1, 1'b1, 11'd0,   1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 11'd0,   1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 11'd0,   1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 11'd0,   1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0};
        tbl[4]  = '{1'b1, 1'b1, 11'd100, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 11'd639, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 11'd640, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 8'd0};
        tbl[7]  = '{1'b1, 1'b0, 11'd640, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 8'd0};
        tbl[8]  = '{1'b1, 1'b1, 11'd640, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 8'd0};
        tbl[9]  = '{1'b1, 1'b1, 11'd640, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 8'd0};
        tbl[10] = '{1'b1, 1'b0, 11'd640, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 8'd0};
        tbl[11] = '{1'b1, 1'b1, 11'd640, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 8'd0};
        tbl[12] = '{1'b1, 1'b0, 11'd640, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 8'd1};

        // Reset held with random activity on the inputs.
        rstbtn_n = 1'b0; pll_lckd = 1'b1; rx_vsync = 1'b1;
        fifo_level = 11'd0; fifo_empty = 1'b0; rd_active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fifo_level = 11'($urandom_range(0, 2047));
            fifo_empty = 1'($urandom_range(0, 1));
            rd_active  = 1'($urandom_range(0, 1));
            tick();
            chk("rst state", {29'd0, state}, 32'd0);
            chk("rst restart", {31'd0, timing_restart}, 32'd1);
            chk("rst capture", {31'd0, capture_en}, 32'd0);
            chk("rst flush", {31'd0, fifo_flush}, 32'd0);
            chk("rst counts", {8'd0, underflow_cnt, frame_cnt}, 32'd0);
        end
        rx_vsync = 1'b1;
        rstbtn_n = 1'b1;

        // Startup through RUN and a first underflow.
        for (int i = 0; i < 13; i++) begin
            pll_lckd = tbl[i].pll; rx_vsync = tbl[i].vs; fifo_level = tbl[i].lvl;
            fifo_empty = tbl[i].emp; rd_active = tbl[i].rd;
            tick();
            chk($sformatf("vec%0d state", i), {29'd0, state}, {29'd0, tbl[i].st});
            chk($sformatf("vec%0d capture", i), {31'd0, capture_en}, {31'd0, tbl[i].cap});
            chk($sformatf("vec%0d flush", i), {31'd0, fifo_flush}, {31'd0, tbl[i].fl});
            chk($sformatf("vec%0d restart", i), {31'd0, timing_restart}, {31'd0, tbl[i].rs});
            chk($sformatf("vec%0d running", i), {31'd0, running}, {31'd0, tbl[i].run});
            chk($sformatf("vec%0d frame_cnt", i), {16'd0, frame_cnt}, {16'd0, tbl[i].fc});
            chk($sformatf("vec%0d underflow_cnt", i), {24'd0, underflow_cnt}, {24'd0, tbl[i].uc});
        end
        exp_fc = 2; exp_uc = 1;

        // Flush pulse length.
        rd_active = 1'b0; fifo_empty = 1'b0; rx_vsync = 1'b0;
        fcount = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (fifo_flush) fcount++;
            else break;
        end
        chk("flush length", fcount, 32'd16);
        chk("after flush state", {29'd0, state}, 32'd1);

        // vsync rise together with underflow: RESYNC, no frame count.
        to_run();
        rx_vsync = 1'b0; tick();
        rx_vsync = 1'b1; rd_active = 1'b1; fifo_empty = 1'b1; tick();
        exp_uc++;
        chk("vs+uf state", {29'd0, state}, 32'd4);
        chk("vs+uf frame_cnt", {16'd0, frame_cnt}, exp_fc);
        chk("vs+uf underflow_cnt", {24'd0, underflow_cnt}, exp_uc);
        rd_active = 1'b0; fifo_empty = 1'b0;

        // Lock loss together with underflow: IDLE, no underflow count.
        to_run();
        pll_lckd = 1'b0; rd_active = 1'b1; fifo_empty = 1'b1; tick();
        chk("pll+uf state", {29'd0, state}, 32'd0);
        chk("pll+uf underflow_cnt", {24'd0, underflow_cnt}, exp_uc);
        chk("pll+uf restart", {31'd0, timing_restart}, 32'd1);
        pll_lckd = 1'b1; rd_active = 1'b0; fifo_empty = 1'b0; tick();
        chk("relock state", {29'd0, state}, 32'd1);

        // Timeout: exactly TMO cycles after the last vsync rise.
        to_run();
        rx_vsync = 1'b0; tick();
        rx_vsync = 1'b1; tick();
        exp_fc++;
        chk("tmo frame_cnt", {16'd0, frame_cnt}, exp_fc);
        fcount = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            fcount++;
            if (state == 3'd4) break;
        end
        chk("timeout cycles", fcount, {12'd0, TMO});

        // vsync rise one cycle before timeout keeps RUN; on the timeout cycle it does not.
        to_run();
        rx_vsync = 1'b0; tick();
        rx_vsync = 1'b1; tick();
        exp_fc++;
        rx_vsync = 1'b0;
        for (int i = 0; i < 198; i++) tick();
        chk("pre-tmo state", {29'd0, state}, 32'd3);
        rx_vsync = 1'b1; tick();
        exp_fc++;
        chk("late vs state", {29'd0, state}, 32'd3);
        chk("late vs frame_cnt", {16'd0, frame_cnt}, exp_fc);
        rx_vsync = 1'b0;
        for (int i = 0; i < 199; i++) tick();
        chk("edge-tmo pre state", {29'd0, state}, 32'd3);
        rx_vsync = 1'b1; tick();
        chk("vs+tmo state", {29'd0, state}, 32'd4);
        chk("vs+tmo frame_cnt", {16'd0, frame_cnt}, exp_fc);

        // Lock loss in FILL.
        wait_state(3'd1);
        fifo_level = 11'd0;
        rx_vsync = 1'b0; tick();
        rx_vsync = 1'b1; tick();
        chk("fill state", {29'd0, state}, 32'd2);
        pll_lckd = 1'b0; tick();
        chk("lock loss state", {29'd0, state}, 32'd0);
        chk("lock loss capture", {31'd0, capture_en}, 32'd0);
        chk("lock loss restart", {31'd0, timing_restart}, 32'd1);
        pll_lckd = 1'b1; tick();
        chk("relock2 state", {29'd0, state}, 32'd1);

        // Underflow count saturates at 255.
        for (int n = 0; n < 300; n++) begin
            to_run();
            rd_active = 1'b1; fifo_empty = 1'b1; tick();
            rd_active = 1'b0; fifo_empty = 1'b0;
            exp_uc = (exp_uc == 255) ? 255 : exp_uc + 1;
            if (n == 250) chk("uc mid", {24'd0, underflow_cnt}, exp_uc);
        end
        chk("uc saturated", {24'd0, underflow_cnt}, 32'd255);
        chk("uc frame_cnt", {16'd0, frame_cnt}, exp_fc);

        // Asynchronous reset mid-RUN.
        to_run();
        #2;
        rstbtn_n = 1'b0;
        #1;
        chk("async state", {29'd0, state}, 32'd0);
        chk("async restart", {31'd0, timing_restart}, 32'd1);
        chk("async running", {31'd0, running}, 32'd0);
        chk("async capture", {31'd0, capture_en}, 32'd0);
        chk("async counts", {8'd0, underflow_cnt, frame_cnt}, 32'd0);
        tick();
        rstbtn_n = 1'b1;
        tick();
        chk("restart state", {29'd0, state}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hdmi_stream_ctrl.md
# hdmi_stream_ctrl

Frame-level sequencer for the HDMI pass-through datapath: RX decoder → pixel FIFO → convolution daisy chain → processed-pixel FIFO → VGA timing generator → TX encoder. It aligns capture to the start of an incoming frame and gates FIFO writes. It holds the TX timing generator in restart until the processed FIFO is prefilled, then detects underflow and lost input frames and resynchronises the chain. It drives the status LED.

## Interface
Parameters:
- LEVEL_W, 11, width of processed-FIFO fill-level input
- PREFILL, 11'd640, processed-FIFO level required before releasing TX timing (one line)
- TIMEOUT_W, 20, width of frame-timeout counter
- TIMEOUT, 20'd840000, cycles without an RX vsync rise before resync (two 800x525 frames)
- FLUSH_CYCLES, 16, length of the fifo_flush pulse in RESYNC (1..255)

Ports:
- clk  in  1  pixel clock (tx0_pclk domain); all inputs synchronous to it
- rstbtn_n  in  1  asynchronous active-low reset
- pll_lckd  in  1  TX PLL / BUFPLL lock
- rx_vsync  in  1  decoded RX vsync, already synchronised to clk
- fifo_level  in  LEVEL_W  processed-FIFO read-side word count
- fifo_empty  in  1  processed-FIFO empty
- rd_active  in  1  timing generator active video (the FIFO rd_en term)
- capture_en  out  1  write gate for the RX pixel FIFO (ANDed with rx_de externally)
- fifo_flush  out  1  synchronous clear request to both FIFOs
- timing_restart  out  1  drives the timing generator restart input
- running  out  1  LED; high only in RUN
- underflow_cnt  out  8  saturating underflow event count
- frame_cnt  out  16  wrapping count of frames completed in RUN
- state  out  3  current state encoding

## Operation
- States: IDLE=0, WAIT_VS=1, FILL=2, RUN=3, RESYNC=4. Codes 5–7 go to IDLE on the next edge.
- vs_rise = rx_vsync & ~vs_d. vs_d is a register whose reset value is 1, so there is no false edge after reset.
- Output decoding in each state:
  - capture_en=1 in FILL and RUN only.
  - timing_restart=0 in RUN only.
  - fifo_flush=1 in RESYNC only.
- Transition priority, highest first: pll_lckd low → IDLE (from any state); underflow; timeout; normal transition.
- IDLE: pll_lckd=1 → WAIT_VS.
- WAIT_VS: vs_rise → FILL. Timeout counter is cleared.
- FILL:
  - fifo_level >= PREFILL → RUN.
  - Timeout counter increments and clears on vs_rise.
  - Counter reaching TIMEOUT-1 → RESYNC.
- RUN:
  - rd_active & fifo_empty → RESYNC; underflow_cnt += 1, saturating at 255.
  - Timeout behaves as in FILL.
  - vs_rise while remaining in RUN → frame_cnt += 1, wrapping at 16 bits.
  - vs_rise in the same cycle as underflow or timeout: no frame_cnt increment.
- RESYNC: flush counter loads FLUSH_CYCLES-1 on entry. It decrements each cycle; at 0 → WAIT_VS.
- Counts (underflow_cnt, frame_cnt) clear only on reset.

## Timing
- All outputs are registered and change on the same clk edge as the state register. Decode is next-state based, so there is no extra cycle.
- Reset values: state=IDLE, capture_en=0, fifo_flush=0, timing_restart=1, running=0, underflow_cnt=0, frame_cnt=0. Internal counters reset to 0 and vs_d resets to 1.
- Latencies:
  - vs_rise at cycle n (input sampled) → capture_en=1 after edge n.
  - Prefill reached → timing_restart=0 one edge later.
  - Underflow sampled → timing_restart=1 and capture_en=0 one edge later.
- fifo_flush is high for exactly FLUSH_CYCLES cycles per RESYNC entry.
- Reset asserted mid-operation forces all outputs to their reset values immediately (asynchronously). Deassertion takes effect at the next edge; the block restarts in IDLE.
- fifo_level >= PREFILL is an unsigned LEVEL_W compare. A level already at or above PREFILL on FILL entry moves to RUN on the next edge.

## Test plan
- Reset: rstbtn_n low, pll_lckd=1, random inputs → state=0, timing_restart=1, capture_en=0, fifo_flush=0, all counts 0. Release → state 0→1 on the first edge.
- Startup: hold rx_vsync high through reset release → no FILL entry. Then pulse 0→1 → capture_en=1 next edge. Ramp fifo_level to 639 → still FILL. Level 640 → RUN, timing_restart=0, running=1 next edge.
- Underflow: in RUN, rd_active=1 and fifo_empty=1 for one cycle → RESYNC, underflow_cnt=1, fifo_flush high exactly 16 cycles, then WAIT_VS. Repeat 300 times → underflow_cnt holds at 255.
- Timeout: in RUN, no vsync edge for 840000 cycles → RESYNC on that cycle count. A vsync rise at cycle 839998 instead keeps RUN and gives frame_cnt+1.
- Simultaneous events: in RUN, vs_rise with underflow in the same cycle → RESYNC, frame_cnt unchanged. pll_lckd low at the same time as underflow → IDLE, underflow_cnt unchanged.
- Lock loss: pll_lckd drops in FILL → IDLE next edge, capture_en=0, timing_restart=1. Relock → WAIT_VS.
